// File: rtl/uart_engine_pkg.sv
// uart_engine_pkg: register map, bit indices and state encodings shared by the UART serial core
package uart_engine_pkg;
  localparam logic [31:0] STAT_ADDR = 32'h00;
  localparam logic [31:0] RDR_ADDR = 32'h08;
  localparam logic [31:0] TDR_ADDR = 32'h0C;
  localparam logic [31:0] CFG_ADDR = 32'h10;
  localparam int STAT_TX_BUSY = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int RDR_VALID = 8;
  localparam int TDR_REQ = 8;
  localparam int CFG_EN = 16;
  localparam int MIN_DIV_DEF = 4;
  typedef enum logic [2:0] {RD_CFG, RD_TDR, TX_CLR, RD_RDR, WR_RDR, WR_STAT} seq_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  function automatic logic [15:0] clamp_div(input logic [15:0] d, input logic [15:0] m);
    return d < m ? m : d;
  endfunction
endpackage

// File: rtl/uart_rx_bit.sv
// uart_rx_bit: synchronises rx, validates the start bit and samples each bit at its midpoint
module uart_rx_bit
  import uart_engine_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic [15:0] div,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        done,
  output logic        stop_err
);
  logic s1, s2, prev;
  rx_t st;
  logic [15:0] rdiv, cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  always_ff @(posedge clk_i) begin
    done <= 1'b0;
    if (!rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      st <= RX_IDLE;
      rdiv <= '0;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      data <= '0;
      stop_err <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      prev <= s2;
      cnt <= cnt + 16'd1;
      case (st)
        RX_IDLE: if (prev && !s2) begin
          st <= RX_START;
          rdiv <= div;
          cnt <= '0;
        end
        RX_START: if (cnt == rdiv >> 1) begin
          st <= s2 ? RX_IDLE : RX_DATA;
          cnt <= '0;
          idx <= '0;
        end
        RX_DATA: if (cnt == rdiv - 16'd1) begin
          sh <= {s2, sh[7:1]};
          cnt <= '0;
          idx <= idx + 3'd1;
          if (idx == 3'd7) st <= RX_STOP;
        end
        RX_STOP: if (cnt == rdiv - 16'd1) begin
          st <= RX_IDLE;
          data <= sh;
          done <= 1'b1;
          stop_err <= !s2;
        end
      endcase
      if (!en) st <= RX_IDLE;
    end
  end
endmodule

// File: rtl/uart_engine.sv
// uart_engine: register-memory sequencer, 8N1 transmitter and receive-side flag bookkeeping
module uart_engine
  import uart_engine_pkg::*;
#(
  parameter int MIN_DIV = MIN_DIV_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        write_o,
  output logic [31:0] wraddr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdaddr_o,
  input  logic [31:0] rdata_i,
  input  logic        rx,
  output logic        tx
);
  seq_t seq;
  logic ph, cfg_en, tx_act, pending, overrun, frame_err, rx_full, rx_done, rx_stop_err;
  logic [15:0] cfg_div, eff_div, tx_div, tx_cnt;
  logic [7:0] tdr_byte, pend_byte, rx_data;
  logic [8:0] tx_sh;
  logic [3:0] tx_bit;
  logic [31:0] stat;
  logic unused_rdata;
  assign eff_div = clamp_div(cfg_div, 16'(MIN_DIV));
  assign unused_rdata = ^rdata_i[31:17];
  always_comb begin
    stat = '0;
    stat[STAT_TX_BUSY] = tx_act;
    stat[STAT_RX_FULL] = rx_full;
    stat[STAT_OVERRUN] = overrun;
    stat[STAT_FRAME_ERR] = frame_err;
  end
  uart_rx_bit u_rx (
    .clk_i(clk_i), .rst_i(rst_i), .en(cfg_en), .div(eff_div), .rx(rx),
    .data(rx_data), .done(rx_done), .stop_err(rx_stop_err)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      seq <= RD_CFG;
      ph <= 1'b0;
      write_o <= 1'b0;
      wraddr_o <= '0;
      wdata_o <= '0;
      rdaddr_o <= '0;
      tx <= 1'b1;
      cfg_en <= 1'b0;
      cfg_div <= '0;
      tx_div <= '0;
      tx_cnt <= '0;
      tx_sh <= '0;
      tx_bit <= '0;
      tx_act <= 1'b0;
      tdr_byte <= '0;
      pend_byte <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      rx_full <= 1'b0;
    end else begin
      write_o <= 1'b0;
      if (tx_act) begin
        if (tx_cnt == tx_div - 16'd1) begin
          tx_cnt <= '0;
          tx <= tx_bit == 4'd9 ? 1'b1 : tx_sh[0];
          tx_sh <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
          tx_act <= tx_bit != 4'd9;
        end else tx_cnt <= tx_cnt + 16'd1;
      end
      // a byte finishing while WR_RDR delivers the old one is not an overrun
      if (rx_done) begin
        pend_byte <= rx_data;
        pending <= 1'b1;
        if (pending && seq != WR_RDR) overrun <= 1'b1;
        if (rx_stop_err) frame_err <= 1'b1;
      end
      case (seq)
        RD_CFG: begin
          ph <= !ph;
          rdaddr_o <= CFG_ADDR;
          if (ph) begin
            cfg_en <= rdata_i[CFG_EN];
            cfg_div <= rdata_i[15:0];
            seq <= RD_TDR;
            if (!rdata_i[CFG_EN]) begin
              tx <= 1'b1;
              tx_act <= 1'b0;
              overrun <= 1'b0;
              frame_err <= 1'b0;
            end
          end
        end
        RD_TDR: begin
          ph <= !ph;
          rdaddr_o <= TDR_ADDR;
          if (ph) begin
            tdr_byte <= rdata_i[7:0];
            seq <= cfg_en && rdata_i[TDR_REQ] && !tx_act ? TX_CLR : pending ? RD_RDR : WR_STAT;
          end
        end
        TX_CLR: begin
          write_o <= 1'b1;
          wraddr_o <= TDR_ADDR;
          wdata_o <= {24'b0, tdr_byte};
          tx <= 1'b0;
          tx_sh <= {1'b1, tdr_byte};
          tx_div <= eff_div;
          tx_cnt <= '0;
          tx_bit <= '0;
          tx_act <= 1'b1;
          seq <= pending ? RD_RDR : WR_STAT;
        end
        RD_RDR: begin
          ph <= !ph;
          rdaddr_o <= RDR_ADDR;
          if (ph) begin
            if (rdata_i[RDR_VALID]) overrun <= 1'b1;
            rx_full <= rdata_i[RDR_VALID];
            seq <= WR_RDR;
          end
        end
        WR_RDR: begin
          write_o <= 1'b1;
          wraddr_o <= RDR_ADDR;
          wdata_o <= {23'b0, 1'b1, pend_byte};
          if (!rx_done) pending <= 1'b0;
          seq <= WR_STAT;
        end
        WR_STAT: begin
          write_o <= 1'b1;
          wraddr_o <= STAT_ADDR;
          wdata_o <= stat;
          seq <= RD_CFG;
        end
        default: seq <= RD_CFG;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_engine.sv
// tb_uart_engine: drives uart_engine through a modelled register memory and checks frames and flags
module tb_uart_engine;
  logic clk = 1'b0;
  logic rst_i, write, rx, tx, loop, rx_drv, sw_we;
  logic [31:0] wraddr, wdata, rdaddr, rdata, sw_data;
  logic [2:0] sw_idx;
  logic [31:0] mem [0:7];
  int compared = 0;
  int mismatched = 0;
  logic m_fe, m_ov, m_full;
  logic [7:0] b;
  int d, e;

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;
  assign rdata = mem[rdaddr[4:2]];
  always_ff @(posedge clk) begin
    if (!rst_i) for (int i = 0; i < 8; i++) mem[i] <= '0;
    else begin
      if (sw_we) mem[sw_idx] <= sw_data;
      if (write) mem[wraddr[4:2]] <= wdata;
    end
  end

  uart_engine dut (
    .clk_i(clk), .rst_i(rst_i), .write_o(write), .wraddr_o(wraddr), .wdata_o(wdata),
    .rdaddr_o(rdaddr), .rdata_i(rdata), .rx(rx), .tx(tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    return {28'b0, m_fe, m_ov, m_full, 1'b0};
  endfunction

  task automatic sw_write(input logic [2:0] idx, input logic [31:0] v);
    sw_we = 1'b1;
    sw_idx = idx;
    sw_data = v;
    @(negedge clk);
    sw_we = 1'b0;
  endtask

  task automatic start_tx(input logic [31:0] cfg, input logic [7:0] v);
    sw_write(3'd4, cfg);
    repeat (20) @(negedge clk);
    sw_write(3'd3, {23'b0, 1'b1, v});
  endtask

  // expected line: start 0, data LSB first, stop 1, each level held for dd clocks
  task automatic capture_tx(input logic [7:0] v, input int dd, input bit mid, input logic [31:0] mid_cfg);
    logic [9:0] f;
    int n, good;
    f = {1'b1, v, 1'b0};
    n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", 32'(n < 300), 32'd1);
    for (int k = 0; k < 10; k++) begin
      good = 0;
      for (int j = 0; j < dd; j++) begin
        if (tx === f[k]) good++;
        if (k == 5 && j == 0) check("tx_busy_mid", mem[0][0], 32'd1);
        if (mid && k == 3 && j == 0) begin
          sw_we = 1'b1;
          sw_idx = 3'd4;
          sw_data = mid_cfg;
        end else if (mid && k == 3 && j == 1) sw_we = 1'b0;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d_len", k), good, dd);
    end
    check("tx_idle_after", tx, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] v, input int dd, input logic stp);
    logic [9:0] f;
    f = {stp, v, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (dd) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rdr(input string tag, input logic [31:0] exp);
    int t;
    t = 0;
    while (mem[2] !== exp && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, mem[2], exp);
  endtask

  initial begin
    rst_i = 1'b0;
    rx_drv = 1'b1;
    loop = 1'b0;
    sw_we = 1'b0;
    sw_idx = '0;
    sw_data = '0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 32'd1);
    check("rst_write", write, 32'd0);
    check("rst_wraddr", wraddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rdaddr", rdaddr, 32'd0);
    rst_i = 1'b1;
    repeat (5) @(negedge clk);

    start_tx(32'h1_0008, 8'hA5);
    capture_tx(8'hA5, 8, 1'b0, 32'd0);
    repeat (30) @(negedge clk);
    check("tdr_cleared_a5", mem[3], 32'h0A5);
    check("stat_idle_a5", mem[0], stat_exp());

    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      d = int'($urandom_range(2, 12));
      e = d < 4 ? 4 : d;
      start_tx(32'h1_0000 | 32'(d), b);
      capture_tx(b, e, 1'b0, 32'd0);
      repeat (30) @(negedge clk);
      check("tdr_cleared_rand", mem[3], {24'b0, b});
    end

    loop = 1'b1;
    start_tx(32'h1_0008, 8'h3C);
    capture_tx(8'h3C, 8, 1'b0, 32'd0);
    wait_rdr("rdr_loop_3c", 32'h13C);
    m_full = 1'b0;
    repeat (40) @(negedge clk);
    check("stat_loop_3c", mem[0], stat_exp());
    start_tx(32'h1_0008, 8'h55);
    capture_tx(8'h55, 8, 1'b0, 32'd0);
    wait_rdr("rdr_loop_55", 32'h155);
    m_full = 1'b1;
    m_ov = 1'b1;
    repeat (40) @(negedge clk);
    check("stat_overrun", mem[0], stat_exp());
    loop = 1'b0;

    sw_write(3'd2, 32'd0);
    sw_write(3'd4, 32'h0_0010);
    repeat (30) @(negedge clk);
    sw_write(3'd4, 32'h1_0010);
    m_ov = 1'b0;
    m_fe = 1'b0;
    repeat (30) @(negedge clk);
    check("stat_after_en_toggle", mem[0], stat_exp());

    for (int r = 0; r < 3; r++) begin
      logic stp;
      b = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      sw_write(3'd2, 32'd0);
      send_rx(b, 16, stp);
      wait_rdr("rdr_rand_rx", {23'b0, 1'b1, b});
      m_full = 1'b0;
      if (!stp) m_fe = 1'b1;
      repeat (30) @(negedge clk);
      check("stat_rand_rx", mem[0], stat_exp());
    end

    sw_write(3'd2, 32'd0);
    send_rx(8'h81, 16, 1'b0);
    wait_rdr("rdr_81_frame_err", 32'h181);
    m_full = 1'b0;
    m_fe = 1'b1;
    repeat (30) @(negedge clk);
    check("stat_frame_err", mem[0], stat_exp());
    sw_write(3'd4, 32'h0_0010);
    repeat (30) @(negedge clk);
    sw_write(3'd4, 32'h1_0010);
    m_fe = 1'b0;
    m_ov = 1'b0;
    repeat (30) @(negedge clk);
    check("stat_fe_cleared", mem[0], stat_exp());

    sw_write(3'd2, 32'd0);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("false_start_rdr", mem[2], 32'd0);
    check("false_start_stat", mem[0], stat_exp());

    start_tx(32'h1_0002, 8'hFF);
    capture_tx(8'hFF, 4, 1'b0, 32'd0);
    repeat (20) @(negedge clk);
    start_tx(32'h1_0002, 8'h35);
    capture_tx(8'h35, 4, 1'b1, 32'h1_000A);
    repeat (30) @(negedge clk);
    check("tdr_cleared_35", mem[3], 32'h035);

    start_tx(32'h1_0008, 8'h00);
    d = 0;
    while (tx !== 1'b0 && d < 300) begin
      @(negedge clk);
      d++;
    end
    check("rst_tx_start_seen", 32'(d < 300), 32'd1);
    repeat (35) @(negedge clk);
    check("tx_low_in_d3", tx, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("midframe_rst_tx", tx, 32'd1);
    check("midframe_rst_write", write, 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    check("resume_rd_cfg", rdaddr, 32'h10);
    repeat (50) @(negedge clk);
    check("tx_idle_after_rst", tx, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
